ma_rw_skid_latch: RTL

Parametrised MA→RW pipeline register with valid/ready handshake, 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It sits between the memory-access and register-write stages. It replaces a fixed-width, always-loading latch: stalls are absorbed without dropping an instruction, and flushes produce a clean NOP bubble.

---
 rtl/ma_rw_skid_latch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ma_rw_skid_latch.sv
// MA->RW pipeline register with a 2-entry skid buffer, flush bubble and saturating stall counter.
// State updates on the falling edge of clk; in_ready/out_valid are registered, so out_ready never reaches in_ready combinationally.
module ma_rw_skid_latch #(
   parameter int                DATA_W = 32,
   parameter int                IR_W   = 32,
   parameter int                CTRL_W = 22,
   parameter logic [IR_W-1:0]   NOP_IR = '0,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_ld_result,
   input  logic [IR_W-1:0]   in_ir,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_ld_result,
   output logic [IR_W-1:0]   out_ir,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t            state;
   state_t            nxt;
   logic              in_fire;
   logic              out_fire;
   logic              ld_main_in;
   logic              ld_main_skid;
   logic              ld_skid;
   logic              bubble;
   logic [DATA_W-1:0] skid_pc;
   logic [DATA_W-1:0] skid_alu_result;
   logic [DATA_W-1:0] skid_ld_result;
   logic [IR_W-1:0]   skid_ir;
   logic [CTRL_W-1:0] skid_ctrl;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Flush overrides every transition, including a same-cycle acceptance.
   always_comb begin
      nxt          = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      bubble       = 1'b0;
      if (flush) begin
         nxt    = EMPTY;
         bubble = 1'b1;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               nxt        = ONE;
               ld_main_in = 1'b1;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  ld_main_in = 1'b1;
               end else if (in_fire) begin
                  nxt     = TWO;
                  ld_skid = 1'b1;
               end else if (out_fire) begin
                  nxt = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               nxt          = ONE;
               ld_main_skid = 1'b1;
            end
            default: nxt = EMPTY;
         endcase
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
      end else begin
         state     <= nxt;
         out_valid <= (nxt != EMPTY);
         in_ready  <= (nxt != TWO);
         occupancy <= (nxt == TWO) ? 2'd2 : ((nxt == ONE) ? 2'd1 : 2'd0);
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         out_pc         <= '0;
         out_alu_result <= '0;
         out_ld_result  <= '0;
         out_ir         <= NOP_IR;
         out_ctrl       <= '0;
      end else if (bubble) begin
         out_pc         <= '0;
         out_alu_result <= '0;
         out_ld_result  <= '0;
         out_ir         <= NOP_IR;
         out_ctrl       <= '0;
      end else if (ld_main_in) begin
         out_pc         <= in_pc;
         out_alu_result <= in_alu_result;
         out_ld_result  <= in_ld_result;
         out_ir         <= in_ir;
         out_ctrl       <= in_ctrl;
      end else if (ld_main_skid) begin
         out_pc         <= skid_pc;
         out_alu_result <= skid_alu_result;
         out_ld_result  <= skid_ld_result;
         out_ir         <= skid_ir;
         out_ctrl       <= skid_ctrl;
      end
   end

   // Skid contents after a flush are stale but unreachable: the FSM is EMPTY.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         skid_pc         <= '0;
         skid_alu_result <= '0;
         skid_ld_result  <= '0;
         skid_ir         <= '0;
         skid_ctrl       <= '0;
      end else if (ld_skid) begin
         skid_pc         <= in_pc;
         skid_alu_result <= in_alu_result;
         skid_ld_result  <= in_ld_result;
         skid_ir         <= in_ir;
         skid_ctrl       <= in_ctrl;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule
